// File: rtl/keypad_code_lock.sv
// keypad_code_lock: 4-digit passcode lock fed by debounced keypad events.
// Digits fill an entry buffer, '#' (F) submits and '*' (E) clears. A matching
// code raises unlock for UNLOCK_CYC cycles. The optional lockout after MAX_FAIL
// consecutive failures is enabled by defining KEYLOCK_LOCKOUT_EN.
// All outputs are registered from next-state values, so a key strobed in one
// cycle shows on S/LEDs/unlock in the following cycle.
module keypad_code_lock #(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000,
    parameter logic [31:0] UNLOCK_CYC  = 32'd300_000_000,
    parameter logic [2:0]  MAX_FAIL    = 3'd3,
    parameter logic [31:0] LOCKOUT_CYC = 32'd1_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [6:0] S,
    output logic [7:0] LEDs,
    output logic       unlock
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Hex digit to {g,f,e,d,c,b,a} active-high glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Digit count to thermometer LED pattern.
    function automatic logic [3:0] thermo(input logic [2:0] n);
        logic [3:0] t;
        case (n)
            3'd0:    t = 4'b0000;
            3'd1:    t = 4'b0001;
            3'd2:    t = 4'b0011;
            3'd3:    t = 4'b0111;
            default: t = 4'b1111;
        endcase
        return t;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic [6:0]  s_q, s_d;
    logic [7:0]  leds_q, leds_d;
    logic        unlock_q, unlock_d;

    logic [31:0] timer_inc;
    logic        is_digit;

    // Next-state logic for the lock FSM, entry buffer, failure count and shared timer.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        err_d     = err_q;
        timer_inc = timer_q + 32'd1;
        is_digit  = (key_code <= 4'd9);
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    err_d = 1'b0;
                    if (is_digit) begin
                        buf_d   = {buf_q[11:0], key_code};
                        count_d = 3'd1;
                        timer_d = 32'd0;
                        state_d = ST_ENTRY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (key_valid) begin
                    // Any key, even an ignored one, restarts the idle timeout.
                    timer_d = 32'd0;
                    if (is_digit) begin
                        if (count_q < 3'd4) begin
                            buf_d   = {buf_q[11:0], key_code};
                            count_d = count_q + 3'd1;
                        end else begin
                            buf_d = buf_q;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d   = 16'h0000;
                        count_d = 3'd0;
                        state_d = ST_IDLE;
                    end else if (key_code == KEY_ENTER) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else if (timer_inc >= TIMEOUT_CYC) begin
                    buf_d   = 16'h0000;
                    count_d = 3'd0;
                    timer_d = 32'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_CHECK: begin
                if ((count_q == 3'd4) && (buf_q == CODE)) begin
                    fail_d  = 3'd0;
                    state_d = ST_OPEN;
                end else begin
                    state_d = ST_FAIL;
                end
                buf_d   = 16'h0000;
                count_d = 3'd0;
                timer_d = 32'd0;
            end
            ST_OPEN: begin
                if (timer_inc >= UNLOCK_CYC) begin
                    timer_d = 32'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_FAIL: begin
                if (fail_q >= MAX_FAIL) begin
                    fail_d = MAX_FAIL;
                end else begin
                    fail_d = fail_q + 3'd1;
                end
                err_d   = 1'b1;
                timer_d = 32'd0;
`ifdef KEYLOCK_LOCKOUT_EN
                if (fail_d == MAX_FAIL) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_LOCKOUT: begin
                // Only reachable when the lockout feature is built in.
                if (timer_inc >= LOCKOUT_CYC) begin
                    timer_d = 32'd0;
                    fail_d  = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                buf_d   = 16'h0000;
                count_d = 3'd0;
                timer_d = 32'd0;
            end
        endcase
    end

    // Output decode from next-state values so outputs register alongside the state.
    always_comb begin
        unlock_d = (state_d == ST_OPEN);
        leds_d[3:0] = thermo(count_d);
        leds_d[4]   = (state_d == ST_OPEN);
        leds_d[5]   = (state_d == ST_FAIL) || err_d;
`ifdef KEYLOCK_LOCKOUT_EN
        leds_d[6]   = (state_d == ST_LOCKOUT);
`else
        leds_d[6]   = 1'b0;
`endif
        leds_d[7]   = (state_d == ST_CHECK) || (state_d == ST_OPEN) ||
                      (state_d == ST_FAIL)  || (state_d == ST_LOCKOUT);
        case (state_d)
            ST_ENTRY:   s_d = hex_glyph(buf_d[3:0]);
            ST_OPEN:    s_d = 7'h3E;
            ST_FAIL:    s_d = 7'h79;
            ST_LOCKOUT: s_d = 7'h40;
            ST_IDLE: begin
                if (err_d) begin
                    s_d = 7'h79;
                end else begin
                    s_d = 7'h00;
                end
            end
            default:    s_d = 7'h00;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            buf_q    <= 16'h0000;
            count_q  <= 3'd0;
            fail_q   <= 3'd0;
            timer_q  <= 32'd0;
            err_q    <= 1'b0;
            s_q      <= 7'h00;
            leds_q   <= 8'h00;
            unlock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            count_q  <= count_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            s_q      <= s_d;
            leds_q   <= leds_d;
            unlock_q <= unlock_d;
        end
    end

    assign S      = s_q;
    assign LEDs   = leds_q;
    assign unlock = unlock_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed testbench for keypad_code_lock with shortened timers.
module tb_keypad_code_lock;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] S;
    logic [7:0] LEDs;
    logic       unlock;

    int checks;
    int failures;
    int n;

    keypad_code_lock #(
        .CODE        (16'h1234),
        .TIMEOUT_CYC (32'd100),
        .UNLOCK_CYC  (32'd50),
        .MAX_FAIL    (3'd3),
        .LOCKOUT_CYC (32'd200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .S         (S),
        .LEDs      (LEDs),
        .unlock    (unlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle key strobe; returns on the negedge after the sampling edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_S", {25'd0, S}, 32'h00);
        check_eq("rst_LEDs", {24'd0, LEDs}, 32'h00);
        check_eq("rst_unlock", {31'd0, unlock}, 32'd0);
        rst_n = 1'b1;

        // Ignored keys in IDLE
        press(4'hE);
        press(4'hA);
        check_eq("idle_ignore_LEDs", {24'd0, LEDs}, 32'h00);

        // Correct code
        press(4'h1);
        check_eq("d1_LEDs", {24'd0, LEDs}, 32'h01);
        check_eq("d1_S", {25'd0, S}, 32'h06);
        press(4'h2);
        press(4'hB);
        check_eq("entry_ignore_LEDs", {24'd0, LEDs}, 32'h03);
        check_eq("entry_ignore_S", {25'd0, S}, 32'h5B);
        press(4'h3);
        press(4'h4);
        check_eq("d4_LEDs", {24'd0, LEDs}, 32'h0F);
        check_eq("d4_S", {25'd0, S}, 32'h66);
        press(4'hF);
        check_eq("check_busy", {31'd0, LEDs[7]}, 32'd1);
        check_eq("check_unlock", {31'd0, unlock}, 32'd0);
        @(negedge clk);
        check_eq("open_LEDs", {24'd0, LEDs}, 32'h90);
        check_eq("open_S", {25'd0, S}, 32'h3E);
        n = 0;
        while (unlock && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("open_len", n, 32'd50);
        check_eq("after_open_LEDs", {24'd0, LEDs}, 32'h00);
        check_eq("after_open_S", {25'd0, S}, 32'h00);

        // Wrong code, short entry
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hF);
        @(negedge clk);
        check_eq("fail_LEDs", {24'd0, LEDs}, 32'hA0);
        check_eq("fail_S", {25'd0, S}, 32'h79);
        check_eq("fail_unlock", {31'd0, unlock}, 32'd0);
        @(negedge clk);
        check_eq("fail_idle_LEDs", {24'd0, LEDs}, 32'h20);
        check_eq("fail_idle_S", {25'd0, S}, 32'h79);
        press(4'h5);
        check_eq("after_fail_LEDs", {24'd0, LEDs}, 32'h01);
        check_eq("after_fail_S", {25'd0, S}, 32'h6D);
        press(4'hE);
        check_eq("clear_LEDs", {24'd0, LEDs}, 32'h00);
        check_eq("clear_S", {25'd0, S}, 32'h00);

        // Fifth digit dropped
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'h5);
        check_eq("drop_LEDs", {24'd0, LEDs}, 32'h0F);
        check_eq("drop_S", {25'd0, S}, 32'h66);
        press(4'hF);
        @(negedge clk);
        check_eq("drop_unlock", {31'd0, unlock}, 32'd1);
        repeat (60) @(negedge clk);
        check_eq("drop_relock", {31'd0, unlock}, 32'd0);

        // Timeout expiry
        press(4'h7);
        press(4'h8);
        repeat (99) @(negedge clk);
        check_eq("pre_timeout_LEDs", {24'd0, LEDs}, 32'h03);
        @(negedge clk);
        check_eq("timeout_LEDs", {24'd0, LEDs}, 32'h00);
        check_eq("timeout_S", {25'd0, S}, 32'h00);

        // Key on the expiry cycle wins
        press(4'h7);
        press(4'h8);
        repeat (98) @(negedge clk);
        press(4'h3);
        check_eq("expiry_key_LEDs", {24'd0, LEDs}, 32'h07);
        check_eq("expiry_key_S", {25'd0, S}, 32'h4F);
        press(4'hE);

        // Three consecutive failures
        for (int i = 0; i < 3; i++) begin
            press(4'h9);
            press(4'hF);
            @(negedge clk);
            @(negedge clk);
        end
`ifdef KEYLOCK_LOCKOUT_EN
        check_eq("lockout_led", {31'd0, LEDs[6]}, 32'd1);
        check_eq("lockout_S", {25'd0, S}, 32'h40);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'hF);
        check_eq("lockout_keys_ignored", {31'd0, LEDs[6]}, 32'd1);
        check_eq("lockout_no_unlock", {31'd0, unlock}, 32'd0);
        n = 11;
        while (n < 400) begin
            @(negedge clk);
            if (LEDs[6]) begin
                n++;
            end else begin
                break;
            end
        end
        check_eq("lockout_len", n, 32'd200);
`else
        check_eq("no_lockout_LEDs", {24'd0, LEDs}, 32'h20);
        check_eq("no_lockout_S", {25'd0, S}, 32'h79);
`endif
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'hF);
        @(negedge clk);
        check_eq("post_fail_unlock", {31'd0, unlock}, 32'd1);

        // Reset during OPEN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_unlock", {31'd0, unlock}, 32'd0);
        check_eq("midrst_LEDs", {24'd0, LEDs}, 32'h00);
        check_eq("midrst_S", {25'd0, S}, 32'h00);
        rst_n = 1'b1;
        press(4'h6);
        check_eq("post_rst_LEDs", {24'd0, LEDs}, 32'h01);
        check_eq("post_rst_S", {25'd0, S}, 32'h7D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
